// File: rtl/hola_parpadeo.sv
// Multi-channel LED pattern generator: a programmable prescaler ticks an off/on/blink/chase pattern.
// leds/tick/wrap are registered; the first tick lands div+1 edges after a load, and en=0 freezes the generator.
module hola_parpadeo #(
   parameter int                   N_LEDS      = 4,
   parameter int                   DIV_WIDTH   = 24,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(12_499_999)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 load,
   input  logic [1:0]           mode,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 dir,
   output logic [N_LEDS-1:0]    leds,
   output logic                 tick,
   output logic                 wrap
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_CHASE = 2'b11
   } mode_t;

   mode_t                r_mode;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] r_cnt;
   logic [N_LEDS-1:0]    r_leds;
   logic                 r_tick;
   logic                 r_wrap;

   logic [N_LEDS-1:0]    w_rot_l;
   logic [N_LEDS-1:0]    w_rot_r;
   logic [N_LEDS-1:0]    w_init;
   logic [N_LEDS-1:0]    w_next;
   logic                 w_wrap_next;

   // Shift-and-or rotations stay legal for N_LEDS=1, where both collapse to the identity.
   assign w_rot_l = (r_leds << 1) | (r_leds >> (N_LEDS - 1));
   assign w_rot_r = (r_leds >> 1) | (r_leds << (N_LEDS - 1));

   always_comb begin
      w_init = '0;
      case (mode_t'(mode))
         MODE_ON:    w_init = '1;
         MODE_CHASE: w_init = N_LEDS'(1);
         default:    w_init = '0;
      endcase
   end

   always_comb begin
      w_next      = '0;
      w_wrap_next = 1'b0;
      case (r_mode)
         MODE_OFF:   w_next = '0;
         MODE_ON:    w_next = '1;
         MODE_BLINK: w_next = ~r_leds;
         MODE_CHASE: begin
            w_next      = dir ? w_rot_r : w_rot_l;
            w_wrap_next = dir ? r_leds[0] : r_leds[N_LEDS-1];
         end
         default:    w_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode <= MODE_OFF;
         r_div  <= DEFAULT_DIV;
         r_cnt  <= '0;
         r_leds <= '0;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end else if (load) begin
         r_mode <= mode_t'(mode);
         r_div  <= div;
         r_cnt  <= '0;
         r_leds <= w_init;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end else if (en) begin
         if (r_cnt == r_div) begin
            r_cnt  <= '0;
            r_leds <= w_next;
            r_tick <= 1'b1;
            r_wrap <= w_wrap_next;
         end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end
   end

   assign leds = r_leds;
   assign tick = r_tick;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_hola_parpadeo.sv
// Self-checking bench for hola_parpadeo: expected {leds,tick,wrap} per edge go through a scoreboard queue.
module tb_hola_parpadeo;

   localparam int N  = 4;
   localparam int DW = 24;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          load;
   logic [1:0]    mode;
   logic [DW-1:0] div;
   logic          dir;
   logic [N-1:0]  leds;
   logic          tick;
   logic          wrap;

   logic [5:0]    sb[$];
   logic [5:0]    exp_v;
   logic [5:0]    got_v;
   int            checks;
   int            errors;

   hola_parpadeo #(
      .N_LEDS   (N),
      .DIV_WIDTH(DW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .load (load),
      .mode (mode),
      .div  (div),
      .dir  (dir),
      .leds (leds),
      .tick (tick),
      .wrap (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One active edge, then settle so outputs are sampled away from the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b1; en = 1'b1; mode = 2'b11; div = 24'd3; dir = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sb.push_back({4'b0000, 1'b0, 1'b0});
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_hold k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
      rst_n = 1'b1; load = 1'b0; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sb.push_back({4'b0000, 1'b0, 1'b0});
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_release k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_chase_left();
      logic [3:0] l;
      int         j;
      load = 1'b1; mode = 2'b11; div = 24'd3; dir = 1'b0; en = 1'b1;
      sb.push_back({4'b0001, 1'b0, 1'b0});
      cyc();
      load = 1'b0;
      got_v = {leds, tick, wrap};
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL chase_load got=%b expected=%b", got_v, exp_v);
      end
      l = 4'b0001;
      j = 0;
      for (int k = 1; k <= 16; k++) begin
         if (k % 4 == 0) begin
            j++;
            l = {l[2:0], l[3]};
            sb.push_back({l, 1'b1, (j == 4)});
         end else begin
            sb.push_back({l, 1'b0, 1'b0});
         end
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL chase_left k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_chase_dir_switch();
      logic [3:0] l;
      int         j;
      load = 1'b1; mode = 2'b11; div = 24'd3; dir = 1'b0; en = 1'b1;
      cyc();
      load = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         sb.push_back({(k == 4) ? 4'b0010 : 4'b0001, (k == 4), 1'b0});
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL dir_first k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
      dir = 1'b1;
      l = 4'b0010;
      j = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k % 4 == 0) begin
            j++;
            l = (j == 1) ? 4'b0001 : (j == 2) ? 4'b1000 : 4'b0100;
            sb.push_back({l, 1'b1, (j == 2)});
         end else begin
            sb.push_back({l, 1'b0, 1'b0});
         end
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL dir_right k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_blink_fast();
      logic [3:0] l;
      load = 1'b1; mode = 2'b10; div = 24'd0; en = 1'b1;
      sb.push_back({4'b0000, 1'b0, 1'b0});
      cyc();
      load = 1'b0;
      got_v = {leds, tick, wrap};
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL blink_load got=%b expected=%b", got_v, exp_v);
      end
      l = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         l = ~l;
         sb.push_back({l, 1'b1, 1'b0});
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL blink_fast k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_en_freeze();
      load = 1'b1; mode = 2'b10; div = 24'd5; en = 1'b1;
      cyc();
      load = 1'b0;
      // 3 counted edges, 7 frozen, then 9 counted: ticks on counted edges 6 and 12.
      for (int k = 1; k <= 19; k++) begin
         en = (k >= 4 && k <= 10) ? 1'b0 : 1'b1;
         if (k == 13)
            sb.push_back({4'b1111, 1'b1, 1'b0});
         else if (k == 19)
            sb.push_back({4'b0000, 1'b1, 1'b0});
         else if (k > 13)
            sb.push_back({4'b1111, 1'b0, 1'b0});
         else
            sb.push_back({4'b0000, 1'b0, 1'b0});
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL en_freeze k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
      en = 1'b1;
   endtask

   task automatic test_back_to_back();
      load = 1'b1; mode = 2'b11; div = 24'd3; dir = 1'b0; en = 1'b1;
      cyc();
      load = 1'b0;
      cyc(); cyc(); cyc();
      // Counter now sits at terminal count; a load here must win over the tick.
      load = 1'b1; mode = 2'b01; div = 24'd2;
      sb.push_back({4'b1111, 1'b0, 1'b0});
      cyc();
      load = 1'b0;
      got_v = {leds, tick, wrap};
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL load_on_terminal got=%b expected=%b", got_v, exp_v);
      end
      for (int k = 1; k <= 3; k++) begin
         sb.push_back({4'b1111, (k == 3), 1'b0});
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL after_load_on k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      load = 1'b1; mode = 2'b11; div = 24'd0; dir = 1'b0; en = 1'b1;
      cyc();
      load = 1'b0;
      cyc(); cyc();
      rst_n = 1'b0;
      sb.push_back({4'b0000, 1'b0, 1'b0});
      cyc();
      rst_n = 1'b1;
      got_v = {leds, tick, wrap};
      exp_v = sb.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL reset_mid got=%b expected=%b", got_v, exp_v);
      end
      for (int k = 1; k <= 4; k++) begin
         sb.push_back({4'b0000, 1'b0, 1'b0});
         cyc();
         got_v = {leds, tick, wrap};
         exp_v = sb.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_off k=%0d got=%b expected=%b", k, got_v, exp_v);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      en     = 1'b0;
      load   = 1'b0;
      mode   = 2'b00;
      div    = '0;
      dir    = 1'b0;
      #1;
      test_reset();
      test_chase_left();
      test_chase_dir_switch();
      test_blink_fast();
      test_en_freeze();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
